// File: rtl/key_entry_if.sv
// Key-code bus between the keypad scanner/test driver and the key_entry block.
interface key_entry_if #(
    parameter int unsigned W = 8
);
    logic [3:0]   IN_value;
    logic         IN_key;
    logic [W-1:0] OUT_a;
    logic [W-1:0] OUT_b;
    logic [2:0]   OUT_op;
    logic         OUT_go;
    logic         OUT_ovf;
    logic [W-1:0] OUT_disp;

    // Scanner side drives key codes and observes the assembled operation
    modport master (
        output IN_value, IN_key,
        input  OUT_a, OUT_b, OUT_op, OUT_go, OUT_ovf, OUT_disp
    );

    // key_entry side
    modport slave (
        input  IN_value, IN_key,
        output OUT_a, OUT_b, OUT_op, OUT_go, OUT_ovf, OUT_disp
    );
endinterface

// File: rtl/key_entry.sv
// Turns level-style scanner key codes into single press events and assembles
// two decimal operands plus an operator, strobing go when '=' is pressed.
module key_entry #(
    parameter int unsigned W           = 8,
    parameter int unsigned RELEASE_CYC = 4
) (
    input  logic       IN_clk,
    input  logic       IN_rst_n,
    key_entry_if.slave bus
);
    localparam int unsigned TW = W + 4;
    localparam int unsigned CW = $clog2(RELEASE_CYC + 1);

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    logic          prev_key;
    logic          armed;
    logic [CW-1:0] rel_cnt;

    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [W-1:0]  disp_q;
    logic [2:0]    op_q;
    logic          go_q;
    logic          ovf_q;

    logic [3:0]    code;
    logic          key_evt;
    logic          is_digit;
    logic          is_eq;
    logic [TW-1:0] acc_src;
    logic [TW-1:0] acc_tmp;
    logic          acc_ovf;

    assign code     = bus.IN_value;
    assign key_evt  = bus.IN_key & ~prev_key & armed;
    assign is_digit = (code <= 4'd9);
    assign is_eq    = (code == 4'd15);

    // Operand under edit times ten plus the digit, wide enough never to wrap
    always_comb begin
        acc_src = (state == S_B) ? TW'(b_q) : TW'(a_q);
        acc_tmp = acc_src * TW'(10) + TW'(code);
        acc_ovf = |acc_tmp[TW-1:W];
    end

    // Release filter: re-arm only after RELEASE_CYC consecutive low samples
    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            prev_key <= 1'b0;
            armed    <= 1'b1;
            rel_cnt  <= CW'(RELEASE_CYC);
        end else begin
            prev_key <= bus.IN_key;
            if (bus.IN_key) begin
                rel_cnt <= '0;
                if (key_evt) begin
                    armed <= 1'b0;
                end
            end else begin
                if (rel_cnt < CW'(RELEASE_CYC)) begin
                    rel_cnt <= rel_cnt + CW'(1);
                end
                if (rel_cnt >= CW'(RELEASE_CYC - 1)) begin
                    armed <= 1'b1;
                end
            end
        end
    end

    // Entry state machine with registered operands, operator, display and strobes
    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            state  <= S_A;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            disp_q <= '0;
            go_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            go_q  <= 1'b0;
            ovf_q <= 1'b0;
            case (state)
                S_A: begin
                    if (key_evt) begin
                        if (is_digit) begin
                            if (acc_ovf) begin
                                ovf_q <= 1'b1;
                            end else begin
                                a_q    <= acc_tmp[W-1:0];
                                disp_q <= acc_tmp[W-1:0];
                            end
                        end else if (!is_eq) begin
                            op_q   <= 3'(code - 4'd10);
                            b_q    <= '0;
                            disp_q <= '0;
                            state  <= S_B;
                        end
                    end
                end
                S_B: begin
                    if (key_evt) begin
                        if (is_digit) begin
                            if (acc_ovf) begin
                                ovf_q <= 1'b1;
                            end else begin
                                b_q    <= acc_tmp[W-1:0];
                                disp_q <= acc_tmp[W-1:0];
                            end
                        end else if (!is_eq) begin
                            op_q <= 3'(code - 4'd10);
                        end else begin
                            go_q  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (key_evt) begin
                        if (is_digit) begin
                            a_q    <= W'(code);
                            b_q    <= '0;
                            disp_q <= W'(code);
                            state  <= S_A;
                        end else if (!is_eq) begin
                            op_q   <= 3'(code - 4'd10);
                            b_q    <= '0;
                            disp_q <= '0;
                            state  <= S_B;
                        end else begin
                            go_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state  <= S_A;
                    disp_q <= a_q;
                end
            endcase
        end
    end

    assign bus.OUT_a    = a_q;
    assign bus.OUT_b    = b_q;
    assign bus.OUT_op   = op_q;
    assign bus.OUT_go   = go_q;
    assign bus.OUT_ovf  = ovf_q;
    assign bus.OUT_disp = disp_q;

endmodule

// File: tb/tb_key_entry.sv
// Bench for key_entry: directed scenarios plus random key streams checked
// against a calculator-level model of the entry rules.
module tb_key_entry;
    localparam int unsigned W    = 8;
    localparam int unsigned RC   = 4;
    localparam int          MAXV = (1 << W) - 1;

    logic IN_clk;
    logic IN_rst_n;

    key_entry_if #(.W(W)) bus ();

    key_entry #(.W(W), .RELEASE_CYC(RC)) dut (
        .IN_clk   (IN_clk),
        .IN_rst_n (IN_rst_n),
        .bus      (bus)
    );

    int checks     = 0;
    int failures   = 0;
    int go_cycles  = 0;
    int ovf_cycles = 0;

    // Reference model: calculator mode 0=A, 1=B, 2=result shown
    int m_mode;
    int m_a;
    int m_b;
    int m_op;
    int m_low_run;
    int m_go_events;
    int m_ovf_events;

    // Clock
    initial begin
        IN_clk = 1'b0;
        forever #5 IN_clk = ~IN_clk;
    end

    // Count strobe-high cycles
    always @(negedge IN_clk) begin
        if (bus.OUT_go === 1'b1) go_cycles++;
        if (bus.OUT_ovf === 1'b1) ovf_cycles++;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_mode    = 0;
        m_a       = 0;
        m_b       = 0;
        m_op      = 0;
        m_low_run = RC;
    endtask

    task automatic model_step(input int code, output bit eg, output bit eo);
        int t;
        eg = 1'b0;
        eo = 1'b0;
        if (code <= 9) begin
            if (m_mode == 2) begin
                m_a = code; m_b = 0; m_mode = 0;
            end else begin
                t = ((m_mode == 0) ? m_a : m_b) * 10 + code;
                if (t > MAXV) eo = 1'b1;
                else if (m_mode == 0) m_a = t;
                else m_b = t;
            end
        end else if (code <= 14) begin
            m_op = code - 10;
            if (m_mode != 1) begin
                m_b = 0; m_mode = 1;
            end
        end else if (m_mode != 0) begin
            eg = 1'b1; m_mode = 2;
        end
        if (eg) m_go_events++;
        if (eo) m_ovf_events++;
    endtask

    task automatic do_reset();
        @(negedge IN_clk);
        IN_rst_n     = 1'b0;
        bus.IN_key   = 1'b0;
        bus.IN_value = 4'd0;
        repeat (2) @(negedge IN_clk);
        IN_rst_n = 1'b1;
        model_reset();
    endtask

    // Drive one key press (hold high cycles, then gap low cycles) and check each step
    task automatic press(input string tag, input int code, input int hold, input int gap);
        bit eg, eo, acc;
        int ed;
        acc = (m_low_run >= RC);
        @(negedge IN_clk);
        bus.IN_key   = 1'b1;
        bus.IN_value = 4'(code);
        @(posedge IN_clk);
        #1;
        eg = 1'b0;
        eo = 1'b0;
        if (acc) model_step(code, eg, eo);
        ed = (m_mode == 0) ? m_a : m_b;
        checks++;
        if (bus.OUT_go !== eg) begin
            failures++;
            $display("FAIL %s go: got=%b exp=%b", tag, bus.OUT_go, eg);
        end
        checks++;
        if (bus.OUT_ovf !== eo) begin
            failures++;
            $display("FAIL %s ovf: got=%b exp=%b", tag, bus.OUT_ovf, eo);
        end
        checks++;
        if (bus.OUT_a !== W'(m_a)) begin
            failures++;
            $display("FAIL %s a: got=%0d exp=%0d", tag, bus.OUT_a, m_a);
        end
        checks++;
        if (bus.OUT_b !== W'(m_b)) begin
            failures++;
            $display("FAIL %s b: got=%0d exp=%0d", tag, bus.OUT_b, m_b);
        end
        checks++;
        if (bus.OUT_op !== 3'(m_op)) begin
            failures++;
            $display("FAIL %s op: got=%0d exp=%0d", tag, bus.OUT_op, m_op);
        end
        checks++;
        if (bus.OUT_disp !== W'(ed)) begin
            failures++;
            $display("FAIL %s disp: got=%0d exp=%0d", tag, bus.OUT_disp, ed);
        end
        for (int i = 1; i < hold; i++) begin
            @(posedge IN_clk);
            #1;
            if (i == 1) begin
                checks++;
                if (bus.OUT_go !== 1'b0 || bus.OUT_ovf !== 1'b0) begin
                    failures++;
                    $display("FAIL %s strobe_end: go=%b ovf=%b exp=0", tag, bus.OUT_go, bus.OUT_ovf);
                end
            end
        end
        @(negedge IN_clk);
        bus.IN_key   = 1'b0;
        bus.IN_value = 4'($urandom);
        for (int i = 0; i < gap; i++) @(posedge IN_clk);
        #1;
        checks++;
        if (bus.OUT_go !== 1'b0 || bus.OUT_ovf !== 1'b0) begin
            failures++;
            $display("FAIL %s strobe_idle: go=%b ovf=%b exp=0", tag, bus.OUT_go, bus.OUT_ovf);
        end
        m_low_run = gap;
    endtask

    task automatic test_reset();
        IN_rst_n     = 1'b0;
        bus.IN_key   = 1'b0;
        bus.IN_value = 4'd0;
        #3;
        checks++;
        if (bus.OUT_a !== '0 || bus.OUT_b !== '0 || bus.OUT_op !== 3'd0 || bus.OUT_disp !== '0) begin
            failures++;
            $display("FAIL reset_data: a=%0d b=%0d op=%0d disp=%0d exp=0", bus.OUT_a, bus.OUT_b, bus.OUT_op, bus.OUT_disp);
        end
        checks++;
        if (bus.OUT_go !== 1'b0 || bus.OUT_ovf !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes: go=%b ovf=%b exp=0", bus.OUT_go, bus.OUT_ovf);
        end
        repeat (2) @(negedge IN_clk);
        IN_rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic_sum();
        int g0;
        do_reset();
        g0 = go_cycles;
        press("sum1", 1, 10, 10);
        press("sum2", 2, 10, 10);
        press("sum+", 10, 10, 10);
        press("sum3", 3, 10, 10);
        press("sum4", 4, 10, 10);
        press("sum=", 15, 10, 10);
        checks++;
        if (bus.OUT_a !== W'(12) || bus.OUT_b !== W'(34) || bus.OUT_op !== 3'd0) begin
            failures++;
            $display("FAIL basic_sum: a=%0d b=%0d op=%0d exp 12 34 0", bus.OUT_a, bus.OUT_b, bus.OUT_op);
        end
        checks++;
        if (go_cycles - g0 != 1) begin
            failures++;
            $display("FAIL basic_sum_go: go_cycles=%0d exp=1", go_cycles - g0);
        end
    endtask

    task automatic test_overflow();
        int o0;
        do_reset();
        o0 = ovf_cycles;
        press("ovf2", 2, 3, 6);
        press("ovf5", 5, 3, 6);
        press("ovf6", 6, 3, 6);
        checks++;
        if (bus.OUT_a !== W'(25) || ovf_cycles - o0 != 1) begin
            failures++;
            $display("FAIL overflow_256: a=%0d ovf_cycles=%0d exp 25 1", bus.OUT_a, ovf_cycles - o0);
        end
        press("ovf5b", 5, 3, 6);
        checks++;
        if (bus.OUT_a !== W'(255) || ovf_cycles - o0 != 1) begin
            failures++;
            $display("FAIL overflow_255: a=%0d ovf_cycles=%0d exp 255 1", bus.OUT_a, ovf_cycles - o0);
        end
    endtask

    task automatic test_hold_glitch();
        do_reset();
        press("hold7", 7, 200, 2);
        checks++;
        if (bus.OUT_a !== W'(7)) begin
            failures++;
            $display("FAIL hold_single: a=%0d exp=7", bus.OUT_a);
        end
        press("glitch7", 7, 5, RC);
        checks++;
        if (bus.OUT_a !== W'(7)) begin
            failures++;
            $display("FAIL glitch_ignored: a=%0d exp=7", bus.OUT_a);
        end
        press("repress7", 7, 5, 6);
        checks++;
        if (bus.OUT_a !== W'(77)) begin
            failures++;
            $display("FAIL release_accept: a=%0d exp=77", bus.OUT_a);
        end
    endtask

    task automatic test_op_replace();
        int g0;
        do_reset();
        g0 = go_cycles;
        press("eqA", 15, 3, 5);
        checks++;
        if (go_cycles != g0) begin
            failures++;
            $display("FAIL eq_in_A: go_cycles=%0d exp=0", go_cycles - g0);
        end
        press("r9", 9, 3, 5);
        press("r+", 10, 3, 5);
        press("rand", 12, 3, 5);
        press("r3", 3, 3, 5);
        press("r=", 15, 3, 5);
        checks++;
        if (bus.OUT_op !== 3'd2 || bus.OUT_b !== W'(3) || bus.OUT_a !== W'(9) || go_cycles - g0 != 1) begin
            failures++;
            $display("FAIL op_replace: op=%0d b=%0d a=%0d go=%0d exp 2 3 9 1", bus.OUT_op, bus.OUT_b, bus.OUT_a, go_cycles - g0);
        end
        press("r==", 15, 3, 5);
        checks++;
        if (bus.OUT_op !== 3'd2 || bus.OUT_b !== W'(3) || bus.OUT_a !== W'(9) || go_cycles - g0 != 2) begin
            failures++;
            $display("FAIL repeat_eq: op=%0d b=%0d a=%0d go=%0d exp 2 3 9 2", bus.OUT_op, bus.OUT_b, bus.OUT_a, go_cycles - g0);
        end
    endtask

    task automatic test_done_transitions();
        do_reset();
        press("d1", 1, 2, 5);
        press("d2", 2, 2, 5);
        press("d+", 10, 2, 5);
        press("d3", 3, 2, 5);
        press("d4", 4, 2, 5);
        press("d=", 15, 2, 5);
        press("dnew4", 4, 2, 5);
        checks++;
        if (bus.OUT_a !== W'(4) || bus.OUT_b !== '0 || bus.OUT_disp !== W'(4)) begin
            failures++;
            $display("FAIL done_digit: a=%0d b=%0d disp=%0d exp 4 0 4", bus.OUT_a, bus.OUT_b, bus.OUT_disp);
        end
        do_reset();
        press("e1", 1, 2, 5);
        press("e2", 2, 2, 5);
        press("e+", 10, 2, 5);
        press("e3", 3, 2, 5);
        press("e4", 4, 2, 5);
        press("e=", 15, 2, 5);
        press("e-", 11, 2, 5);
        checks++;
        if (bus.OUT_a !== W'(12) || bus.OUT_op !== 3'd1 || bus.OUT_b !== '0) begin
            failures++;
            $display("FAIL done_op: a=%0d op=%0d b=%0d exp 12 1 0", bus.OUT_a, bus.OUT_op, bus.OUT_b);
        end
    endtask

    task automatic test_reset_mid_entry();
        do_reset();
        press("m5", 5, 3, 5);
        press("m6", 6, 3, 5);
        @(negedge IN_clk);
        #2;
        IN_rst_n = 1'b0;
        #1;
        checks++;
        if (bus.OUT_a !== '0 || bus.OUT_b !== '0 || bus.OUT_op !== 3'd0 || bus.OUT_disp !== '0 ||
            bus.OUT_go !== 1'b0 || bus.OUT_ovf !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: a=%0d b=%0d op=%0d disp=%0d go=%b ovf=%b exp all 0",
                     bus.OUT_a, bus.OUT_b, bus.OUT_op, bus.OUT_disp, bus.OUT_go, bus.OUT_ovf);
        end
        @(negedge IN_clk);
        IN_rst_n = 1'b1;
        model_reset();
        press("m3", 3, 3, 5);
        checks++;
        if (bus.OUT_a !== W'(3)) begin
            failures++;
            $display("FAIL after_reset: a=%0d exp=3", bus.OUT_a);
        end
    endtask

    task automatic test_random();
        int g0, o0, mg0, mo0, r, code;
        do_reset();
        g0  = go_cycles;
        o0  = ovf_cycles;
        mg0 = m_go_events;
        mo0 = m_ovf_events;
        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      code = $urandom_range(0, 9);
            else if (r < 85) code = $urandom_range(10, 14);
            else             code = 15;
            press("rnd", code, $urandom_range(1, 8), $urandom_range(1, 7));
        end
        checks++;
        if (go_cycles - g0 != m_go_events - mg0) begin
            failures++;
            $display("FAIL rnd_go_count: got=%0d exp=%0d", go_cycles - g0, m_go_events - mg0);
        end
        checks++;
        if (ovf_cycles - o0 != m_ovf_events - mo0) begin
            failures++;
            $display("FAIL rnd_ovf_count: got=%0d exp=%0d", ovf_cycles - o0, m_ovf_events - mo0);
        end
    endtask

    initial begin
        m_go_events  = 0;
        m_ovf_events = 0;
        model_reset();
        test_reset();
        test_basic_sum();
        test_overflow();
        test_hold_glitch();
        test_op_replace();
        test_done_transitions();
        test_reset_mid_entry();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
